// File: rtl/seg7_pkg.sv
// Shared glyph constants and display FSM state for the note display.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  localparam logic [9:0][6:0] GLYPH = {
    7'b0010000,
    7'b0000000,
    7'b1111000,
    7'b0000010,
    7'b0010010,
    7'b0011001,
    7'b0110000,
    7'b0100100,
    7'b1111001,
    7'b1000000
  };

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    HOLD
  } disp_state_t;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational digit to active-low glyph decoder.
// Non-decimal codes render as 'E'.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_E;
    if (digit_i <= 4'd9) begin
      seg_o = GLYPH[digit_i];
    end
  end

endmodule

// File: rtl/seg7_note_display.sv
// Two-digit multiplexed note display with hold-after-play,
// leading-zero blanking and an idle dash pattern.
module seg7_note_display
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYCLES = 64,
  parameter int HOLD_CYCLES = 25000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       PLAYING,
  input  logic [3:0] BCD1,
  input  logic [3:0] BCD0,
  output logic [6:0] SEG,
  output logic [1:0] DIG,
  output logic       HOLDING
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int HW =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  disp_state_t   state_q, state_d;
  logic [SW-1:0] scan_q, scan_d;
  logic          sel_q, sel_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    units_q, units_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    dig_q, dig_d;
  logic          holding_q, holding_d;

  logic [3:0]    digit;
  logic [6:0]    glyph;

  assign digit = sel_q ? tens_q : units_q;

  seg7_decoder u_dec (
    .digit_i (digit),
    .seg_o   (glyph)
  );

  always_comb begin
    state_d = state_q;
    scan_d  = scan_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    tens_d  = tens_q;
    units_d = units_q;
    if (EN) begin
      if (scan_q == SW'(SCAN_DIV - 1)) begin
        scan_d = '0;
        sel_d  = ~sel_q;
      end else begin
        scan_d = scan_q + SW'(1);
      end
      unique case (state_q)
        IDLE: begin
          if (PLAYING) begin
            state_d = SHOW;
            tens_d  = BCD1;
            units_d = BCD0;
          end
        end
        SHOW: begin
          if (PLAYING) begin
            tens_d  = BCD1;
            units_d = BCD0;
          end else begin
            state_d = HOLD;
            hold_d  = '0;
          end
        end
        HOLD: begin
          if (PLAYING) begin
            state_d = SHOW;
            hold_d  = '0;
            tens_d  = BCD1;
            units_d = BCD0;
          end else if (hold_q == HW'(HOLD_CYCLES - 1)) begin
            state_d = IDLE;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    holding_d = (state_d == HOLD);
  end

  // Dead time keeps both anodes off so the glyph switch cannot ghost.
  always_comb begin
    seg_d = SEG_BLANK;
    dig_d = 2'b11;
    if (EN && (scan_q >= SW'(DEAD_CYCLES))) begin
      dig_d = sel_q ? 2'b01 : 2'b10;
      if (state_q == IDLE) begin
        seg_d = SEG_DASH;
      end else if (sel_q && (tens_q == 4'd0)) begin
        seg_d = SEG_BLANK;
      end else begin
        seg_d = glyph;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      scan_q    <= '0;
      sel_q     <= 1'b0;
      hold_q    <= '0;
      tens_q    <= 4'd0;
      units_q   <= 4'd0;
      seg_q     <= SEG_BLANK;
      dig_q     <= 2'b11;
      holding_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      scan_q    <= scan_d;
      sel_q     <= sel_d;
      hold_q    <= hold_d;
      tens_q    <= tens_d;
      units_q   <= units_d;
      seg_q     <= seg_d;
      dig_q     <= dig_d;
      holding_q <= holding_d;
    end
  end

  assign SEG     = seg_q;
  assign DIG     = dig_q;
  assign HOLDING = holding_q;

endmodule
